// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_rd_ctrl : read-side pointer/flag controller of a dual-clock FIFO.
// Optional almost-empty output enabled by defining FIFO_RD_AEMPTY_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
module fifo_rd_ctrl #(
  parameter int ADDR_W    = 4,
  parameter int AEMPTY_TH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W:0]   wptr_gray_s,
  output logic [ADDR_W:0]   rptr_gray,
  output logic [ADDR_W-1:0] raddr,
  output logic              rd_fire,
  output logic              empty,
  output logic [ADDR_W:0]   rd_level,
  output logic              underflow
`ifdef FIFO_RD_AEMPTY_EN
  ,
  output logic              aempty
`endif
);

  logic [ADDR_W:0] rbin;
  logic [ADDR_W:0] rbin_next;
  logic [ADDR_W:0] gray_next;
  logic [ADDR_W:0] wbin;
  logic [ADDR_W:0] level_next;

  assign rd_fire    = rd_en & ~empty;
  assign rbin_next  = rbin + {{ADDR_W{1'b0}}, rd_fire};
  assign gray_next  = rbin_next ^ (rbin_next >> 1);
  assign level_next = wbin - rbin_next;
  assign raddr      = rbin[ADDR_W-1:0];

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wbin = '0;
    for (int i = 0; i <= ADDR_W; i++) begin
      wbin[i] = ^(wptr_gray_s >> i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rbin      <= '0;
      rptr_gray <= '0;
      empty     <= 1'b1;
      rd_level  <= '0;
      underflow <= 1'b0;
    end else begin
      rbin      <= rbin_next;
      rptr_gray <= gray_next;
      empty     <= (gray_next == wptr_gray_s);
      rd_level  <= level_next;
      underflow <= underflow | (rd_en & empty);
    end
  end

`ifdef FIFO_RD_AEMPTY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aempty <= 1'b1;
    end else begin
      aempty <= (level_next <= (ADDR_W+1)'(AEMPTY_TH));
    end
  end
`endif

  // A threshold above the buffer depth would make the almost-empty flag stuck high.
  generate
    if (AEMPTY_TH < 0 || AEMPTY_TH > (1 << ADDR_W)) begin : g_th_check
      $error("fifo_rd_ctrl: AEMPTY_TH out of range");
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fifo_rd_ctrl : randomized scoreboard bench for fifo_rd_ctrl (ADDR_W=4).
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_fifo_rd_ctrl;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW:0]   wptr_gray_s = '0;
  logic [AW:0]   rptr_gray;
  logic [AW-1:0] raddr;
  logic          rd_fire;
  logic          empty;
  logic [AW:0]   rd_level;
  logic          underflow;
`ifdef FIFO_RD_AEMPTY_EN
  logic          aempty;
`endif

  fifo_rd_ctrl #(.ADDR_W(AW), .AEMPTY_TH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (rd_en),
    .wptr_gray_s (wptr_gray_s),
    .rptr_gray   (rptr_gray),
    .raddr       (raddr),
    .rd_fire     (rd_fire),
    .empty       (empty),
    .rd_level    (rd_level),
    .underflow   (underflow)
`ifdef FIFO_RD_AEMPTY_EN
    ,
    .aempty      (aempty)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW:0]   gray;
    logic [AW-1:0] addr;
    logic          emp;
    logic [AW:0]   lvl;
    logic          uf;
    logic          fire;
    logic          ae;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: counts of entries read/written, flags derived from them.
  int m_rd = 0;
  int m_level = 0;
  bit m_empty = 1'b1;
  bit m_uf = 1'b0;
  bit m_ae = 1'b1;
  bit cur_rd = 1'b0;
  bit cur_rst = 1'b0;
  int cur_w = 0;

  function automatic logic [AW:0] gray(input int b);
    logic [AW:0] v;
    v = b[AW:0];
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock: retire the previous cycle's inputs into the model, apply new ones.
  task automatic step(input bit rd, input int w, input bit r);
    bit fire;
    exp_t e;
    @(posedge clk);
    #1;
    if (cur_rst) begin
      fire    = cur_rd && !m_empty;
      m_uf    = m_uf | (cur_rd && m_empty);
      m_rd    = m_rd + int'(fire);
      m_level = (cur_w - m_rd) & ((1 << (AW + 1)) - 1);
      m_empty = (m_level == 0);
      m_ae    = (m_level <= 2);
    end
    rst         = r;
    rd_en       = rd;
    wptr_gray_s = gray(w);
    cur_rst     = r;
    cur_rd      = rd;
    cur_w       = w;
    if (!r) begin
      m_rd = 0; m_level = 0; m_empty = 1'b1; m_uf = 1'b0; m_ae = 1'b1;
    end
    e.gray = gray(m_rd);
    e.addr = m_rd[AW-1:0];
    e.emp  = m_empty;
    e.lvl  = m_level[AW:0];
    e.uf   = m_uf;
    e.fire = rd && !m_empty && r;
    e.ae   = m_ae;
    q.push_back(e);
  endtask

  // Monitor: compare DUT outputs mid-cycle against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("rptr_gray", 32'(rptr_gray), 32'(e.gray));
      chk("raddr",     32'(raddr),     32'(e.addr));
      chk("empty",     32'(empty),     32'(e.emp));
      chk("rd_level",  32'(rd_level),  32'(e.lvl));
      chk("underflow", 32'(underflow), 32'(e.uf));
      chk("rd_fire",   32'(rd_fire),   32'(e.fire));
`ifdef FIFO_RD_AEMPTY_EN
      chk("aempty",    32'(aempty),    32'(e.ae));
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int  w;
    bit  rd;
    bit  rv;
    bit  fill_phase;
    // reset with a pending read request
    step(1'b1, 0, 1'b0);
    step(1'b0, 0, 1'b1);
    // basic drain of three entries, then underflow attempts
    step(1'b0, 3, 1'b1);
    step(1'b0, 3, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 3, 1'b1);
    step(1'b0, 3, 1'b1);
    step(1'b1, 3, 1'b1);
    step(1'b1, 3, 1'b1);
    step(1'b0, 3, 1'b1);
    step(1'b0, 3, 1'b1);
    // full level from a fresh reset
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b1);
    step(1'b0, 16, 1'b1);
    step(1'b0, 16, 1'b1);
    step(1'b0, 16, 1'b0);
    step(1'b0, 0, 1'b1);
    // randomized traffic, alternating fill-heavy and drain-heavy phases,
    // with an asynchronous reset in the middle
    w = 0;
    for (int i = 0; i < 800; i++) begin
      fill_phase = ((i / 60) % 2) == 0;
      rd = ($urandom % 100) < (fill_phase ? 30 : 80);
      if ((w - m_rd) < 16 && ($urandom % 100) < (fill_phase ? 75 : 20)) w++;
      rv = (i != 400);
      if (!rv) w = 0;
      step(rd, w, rv);
    end
    step(1'b0, w, 1'b1);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
